// File: rtl/vga_frame_capture.sv
// VGA frame grabber: recovers position/lock from hsync/vsync and writes one 2x-decimated frame into block RAM.
// Latency: pin to RAM write 2 clocks; no backpressure, the RAM write port accepts every cycle.
module vga_frame_capture #(
  parameter int H_TOTAL  = 800,
  parameter int H_SKIP   = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SKIP   = 35,
  parameter int V_ACTIVE = 480,
  parameter int IMG_W    = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [11:0] rgb_in,
  input  logic        start,
  output logic        wea,
  output logic [16:0] addra,
  output logic [11:0] dina,
  output logic        busy,
  output logic        done,
  output logic        locked,
  output logic [9:0]  line_len
);

  localparam logic [9:0]  CNT_MAX = 10'h3ff;
  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_LO    = 10'(H_SKIP);
  localparam logic [9:0]  H_HI    = 10'(H_SKIP + H_ACTIVE);
  localparam logic [9:0]  V_LO    = 10'(V_SKIP);
  localparam logic [9:0]  V_HI    = 10'(V_SKIP + V_ACTIVE);
  localparam logic [16:0] IMG_W_V = 17'(IMG_W);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  logic        s1_h, s1_v, s2_h, s2_v;
  logic [11:0] s1_rgb;
  logic        hs_fall, vs_fall;
  logic [9:0]  h_cnt, v_cnt;
  logic        hs_seen, vs_seen, frame_good;
  logic        bad_line;
  logic [1:0]  ok_cnt, ok_nxt;
  logic        lock_nxt;
  logic        h_act, v_act;
  logic [9:0]  x, y;
  logic [8:0]  xh, yh;
  logic [16:0] row_base, wr_addr;
  logic        wr_go;
  state_t      state, state_nxt;
  logic        capturing;

  // Syncs idle high so a stream that starts low right after reset still yields a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_h   <= 1'b1;
      s1_v   <= 1'b1;
      s2_h   <= 1'b1;
      s2_v   <= 1'b1;
      s1_rgb <= '0;
    end else begin
      s1_h   <= hsync_in;
      s1_v   <= vsync_in;
      s2_h   <= s1_h;
      s2_v   <= s1_v;
      s1_rgb <= rgb_in;
    end
  end

  assign hs_fall  = s2_h & ~s1_h;
  assign vs_fall  = s2_v & ~s1_v;
  assign bad_line = hs_fall & hs_seen & (h_cnt != H_LAST);

  always_comb begin
    ok_nxt = ok_cnt;
    if (bad_line) begin
      ok_nxt = 2'd0;
    end else if (vs_fall) begin
      if (vs_seen && frame_good && (v_cnt == V_LAST)) begin
        ok_nxt = (ok_cnt == 2'd2) ? 2'd2 : ok_cnt + 2'd1;
      end else begin
        ok_nxt = 2'd0;
      end
    end
  end

  assign lock_nxt = (ok_nxt == 2'd2);
  assign locked   = (ok_cnt == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      line_len   <= '0;
      hs_seen    <= 1'b0;
      vs_seen    <= 1'b0;
      frame_good <= 1'b0;
      ok_cnt     <= 2'd0;
    end else begin
      if (hs_fall) begin
        h_cnt <= '0;
      end else if (h_cnt != CNT_MAX) begin
        h_cnt <= h_cnt + 10'd1;
      end

      if (vs_fall) begin
        v_cnt <= '0;
      end else if (hs_fall && (v_cnt != CNT_MAX)) begin
        v_cnt <= v_cnt + 10'd1;
      end

      // The first line after reset has an unknown start, so it is not measured.
      if (hs_fall) begin
        hs_seen <= 1'b1;
        if (hs_seen) begin
          line_len <= (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 10'd1;
        end
      end

      if (vs_fall) begin
        vs_seen <= 1'b1;
      end

      if (vs_fall) begin
        frame_good <= 1'b1;
      end else if (bad_line) begin
        frame_good <= 1'b0;
      end

      ok_cnt <= ok_nxt;
    end
  end

  assign h_act = (h_cnt >= H_LO) && (h_cnt < H_HI);
  assign v_act = (v_cnt >= V_LO) && (v_cnt < V_HI);
  assign x     = h_cnt - H_LO;
  assign y     = v_cnt - V_LO;
  assign xh    = x[9:1];
  assign yh    = y[9:1];

  // Row base as a sum of shifted copies of the row index, one term per set bit of the pitch.
  always_comb begin
    row_base = '0;
    for (int i = 0; i < 17; i++) begin
      if (IMG_W_V[i]) begin
        row_base = row_base + (17'(yh) << i);
      end
    end
    wr_addr = row_base + 17'(xh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     if (vs_fall && lock_nxt) state_nxt = CAPTURE;
      CAPTURE: begin
        if (!lock_nxt) begin
          state_nxt = ARM;
        end else if (v_cnt == V_HI) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    capturing = 1'b0;
    case (state)
      ARM:     busy = 1'b1;
      CAPTURE: begin
        busy      = 1'b1;
        capturing = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign wr_go = capturing & lock_nxt & h_act & v_act & ~x[0] & ~y[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
    end else begin
      wea <= wr_go;
      if (wr_go) begin
        addra <= wr_addr;
        dina  <= s1_rgb;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Scoreboard bench for vga_frame_capture on a scaled-down video geometry (40x30 clocks per frame).
// The driver pushes expected RAM writes and done pulses; a negedge monitor pops and compares them.
module tb_vga_frame_capture;

  localparam int H_TOTAL  = 40;
  localparam int H_SKIP   = 8;
  localparam int H_ACTIVE = 16;
  localparam int V_TOTAL  = 30;
  localparam int V_SKIP   = 4;
  localparam int V_ACTIVE = 12;
  localparam int IMG_W    = 8;
  localparam int HS_W     = 4;
  localparam int VS_W     = 2;
  localparam int N_ROWS   = V_ACTIVE / 2;

  logic        clk = 1'b0;
  logic        rst, hsync_in, vsync_in, start;
  logic [11:0] rgb_in;
  logic        wea, busy, done, locked;
  logic [16:0] addra;
  logic [11:0] dina;
  logic [9:0]  line_len;

  always #5 clk = ~clk;

  vga_frame_capture #(
    .H_TOTAL(H_TOTAL), .H_SKIP(H_SKIP), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SKIP(V_SKIP), .V_ACTIVE(V_ACTIVE), .IMG_W(IMG_W)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
    .start(start), .wea(wea), .addra(addra), .dina(dina), .busy(busy), .done(done),
    .locked(locked), .line_len(line_len)
  );

  typedef struct packed {
    logic [16:0] addr;
    logic [11:0] dat;
  } wr_t;

  wr_t exp_wr[$];
  wr_t mon_e;
  int  exp_done = 0;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The DUT writes s1 data while h_cnt already counts from the sample after the sync edge,
  // so pixel column 0 is the pin sample H_SKIP+1 clocks after the hsync falling edge.
  function automatic logic [11:0] pix(input int hc, input int vc, input int tag);
    logic [9:0] px, py;
    logic [3:0] t;
    px = 10'(hc - H_SKIP - 1);
    py = 10'(vc - V_SKIP);
    t  = 4'(tag);
    return {px[3:0], py[3:0], t};
  endfunction

  task automatic push_frame(input int tag, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        logic [9:0] xv, yv;
        wr_t e;
        xv     = 10'(2 * c);
        yv     = 10'(2 * r);
        e.addr = 17'(r * IMG_W + c);
        e.dat  = {xv[3:0], yv[3:0], 4'(tag)};
        exp_wr.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (wea === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addra=%0d dina=%03h, none expected (t=%0t)", addra, dina, $time);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_addra", 32'(addra), 32'(mon_e.addr));
        chk("wr_dina", 32'(dina), 32'(mon_e.dat));
      end
    end
    if (done === 1'b1) begin
      if (exp_done == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: done=1 with no capture outstanding (t=%0t)", $time);
      end else begin
        exp_done--;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // One frame of pins; bad_vc shortens that line by one clock, start/rst pulse on the given lines.
  task automatic run_frame(input int fno, input int bad_vc, input int start_vc, input int rst_vc,
                           input logic lk0, input logic lk1, input int busy_end);
    for (int vc = 0; vc < V_TOTAL; vc++) begin
      int len;
      len = (vc == bad_vc) ? H_TOTAL - 1 : H_TOTAL;
      for (int hc = 0; hc < len; hc++) begin
        @(negedge clk);
        if (vc == 0 && hc == 1) chk("lock_before_vs", 32'(locked), 32'(lk0));
        if (vc == 0 && hc == 2) chk("lock_after_vs", 32'(locked), 32'(lk1));
        if (vc == 1 && hc == 2) chk("line_len", 32'(line_len), 32'(H_TOTAL));
        if (bad_vc >= 0 && vc == bad_vc + 1 && hc == 1) chk("lock_before_bad", 32'(locked), 32'd1);
        if (bad_vc >= 0 && vc == bad_vc + 1 && hc == 2) begin
          chk("lock_after_bad", 32'(locked), 32'd0);
          chk("line_len_bad", 32'(line_len), 32'(H_TOTAL - 1));
        end
        if (vc == start_vc && hc == 5) start = 1'b1;
        if (vc == start_vc && hc == 6) begin
          start = 1'b0;
          chk("busy_after_start", 32'(busy), 32'd1);
        end
        if (vc == rst_vc && hc == 3) begin
          rst = 1'b1;
          #1;
          chk("midrst_wea", 32'(wea), 32'd0);
          chk("midrst_busy", 32'(busy), 32'd0);
          chk("midrst_locked", 32'(locked), 32'd0);
          chk("midrst_addra", 32'(addra), 32'd0);
          chk("midrst_done", 32'(done), 32'd0);
        end
        if (vc == rst_vc && hc == 6) rst = 1'b0;
        if (busy_end >= 0 && vc == V_TOTAL - 1 && hc == len - 1)
          chk("busy_frame_end", 32'(busy), 32'(busy_end));
        hsync_in = (hc >= HS_W);
        vsync_in = (vc >= VS_W);
        rgb_in   = pix(hc, vc, fno);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    rgb_in   = '0;
    start    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      rgb_in   = 12'($urandom);
      start    = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_wea", 32'(wea), 32'd0);
    chk("rst_addra", 32'(addra), 32'd0);
    chk("rst_dina", 32'(dina), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_line_len", 32'(line_len), 32'd0);
    start    = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    rst      = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Start while unlocked: waits in ARM, captures frame 2 once lock is reached.
    push_frame(2, N_ROWS);
    exp_done++;
    run_frame(0, -1, 3, -1, 1'b0, 1'b0, 1);
    run_frame(1, -1, -1, -1, 1'b0, 1'b0, 1);
    run_frame(2, -1, 5, -1, 1'b0, 1'b1, 0);

    // Capture of frame 4 aborted by a short line at y=5 (rows 0,2,4 written), retried on frame 7.
    push_frame(4, 3);
    push_frame(7, N_ROWS);
    exp_done++;
    run_frame(3, -1, 0, -1, 1'b1, 1'b1, 1);
    run_frame(4, V_SKIP + 5, -1, -1, 1'b1, 1'b1, 1);
    run_frame(5, -1, -1, -1, 1'b0, 1'b0, 1);
    run_frame(6, -1, -1, -1, 1'b0, 1'b0, 1);
    run_frame(7, -1, -1, -1, 1'b0, 1'b1, 0);

    // Capture of frame 9 cut by reset at y=8: rows 0,2,4,6 written, no done.
    push_frame(9, 4);
    run_frame(8, -1, 2, -1, 1'b1, 1'b1, 1);
    run_frame(9, -1, -1, V_SKIP + 8, 1'b1, 1'b1, 0);
    run_frame(10, -1, -1, -1, 1'b0, 1'b0, 0);

    chk("writes_outstanding", 32'(exp_wr.size()), 32'd0);
    chk("dones_outstanding", 32'(exp_done), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Pixel-clock-domain VGA frame grabber: the receiving end of the 640x480@60 sync/colour stream the display path generates. Samples hsync/vsync/12-bit RGB, recovers horizontal/vertical position, checks timing lock, and on request writes one 2x-decimated 320x240 frame into the 76800-entry frame-buffer block RAM through its write port (wea/addra/dina). The display path reads that same RAM.

## Interface
- H_TOTAL, 800, clocks per line
- H_SKIP, 144, clocks from hsync falling edge to first active pixel (sync 96 + back porch 48)
- H_ACTIVE, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_SKIP, 35, lines from vsync falling edge to first active line (sync 2 + back porch 33)
- V_ACTIVE, 480, active lines per frame
- IMG_W, 320, stored image width (row pitch of addra)

- clk  in  1  25 MHz pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- hsync_in  in  1  horizontal sync, active low
- vsync_in  in  1  vertical sync, active low
- rgb_in  in  12  {R[3:0],G[3:0],B[3:0]}, valid every clock
- start  in  1  one-cycle capture request
- wea  out  1  RAM write enable
- addra  out  17  RAM write address, 0..76799
- dina  out  12  RAM write data
- busy  out  1  high from accepted start until done or reset
- done  out  1  one-cycle pulse, frame fully written
- locked  out  1  input timing matches parameters
- line_len  out  10  clocks in last completed line

## Operation
- Input stage: hsync_in/vsync_in/rgb_in registered (s1); syncs registered again (s2). hs_fall = s2_h & ~s1_h; vs_fall likewise.
- h_cnt: 0 on hs_fall, else +1, saturating at 1023. At hs_fall, line_len <= previous h_cnt + 1 (skipped on the first hs_fall after reset).
- v_cnt: 0 on vs_fall (priority), else +1 on hs_fall, saturating at 1023.
- Active when H_SKIP <= h_cnt < H_SKIP+H_ACTIVE and V_SKIP <= v_cnt < V_SKIP+V_ACTIVE; x = h_cnt-H_SKIP, y = v_cnt-V_SKIP.
- Lock: frame_good set at vs_fall; cleared by any checked hs_fall with line length != H_TOTAL. ok_cnt (0..2): at vs_fall, if a prior vs_fall was seen, frame_good=1 and v_cnt==V_TOTAL-1, then ok_cnt=min(ok_cnt+1,2), else 0. Bad line length also zeroes ok_cnt immediately. locked = (ok_cnt==2).
- FSM:
  - IDLE: busy=0; start -> ARM.
  - ARM: busy=1; vs_fall with locked=1 (post-update) -> CAPTURE; otherwise stay.
  - CAPTURE: write when active & x[0]==0 & y[0]==0: addra=(y>>1)*IMG_W+(x>>1), dina=s1 rgb. When v_cnt becomes V_SKIP+V_ACTIVE -> DONE. locked falling -> ARM (no done; retry on a later locked frame).
  - DONE: done=1 for one cycle, busy=0, -> IDLE.
- start ignored outside IDLE. No writes outside CAPTURE.
- Address arithmetic: 17-bit; (y>>1)*IMG_W implemented as shift-add (256+64).

## Timing
- Reset (async): wea=0, addra=0, dina=0, busy=0, done=0, locked=0, line_len=0, counters 0, ok_cnt 0, FSM IDLE. rst mid-capture drops wea/busy immediately; no done.
- Latency: pin sample -> s1 1 clock; wea/addra/dina registered 1 clock after the active s1 cycle; pin-to-write 2 clocks.
- Writes per captured frame: exactly 76800, addresses strictly increasing 0..76799; each on one cycle; no pixel written twice.
- busy rises the cycle after start; done occurs 1 cycle after the last write's line ends (v_cnt reaching 515), coincident with busy falling.
- locked rises in the cycle after the vs_fall that completes the second consecutive good frame; falls the cycle after the offending hs_fall/vs_fall.
- Simultaneous hs_fall and vs_fall: v_cnt=0, h_cnt=0, line check still performed.

## Test plan
- Reset: hold rst, drive arbitrary syncs -> all outputs 0; release, no writes without start.
- Lock: standard 800x525 stream from t=0 -> locked=1 one cycle after the 3rd vs_fall, line_len=800.
- Capture: locked, rgb={x[3:0],y[3:0],4'h5}, pulse start -> 76800 writes, first addra=0 dina=12'h005, addra=321 carries x=2,y=2 (12'h225), last addra=76799; one done pulse; busy low after.
- Lock loss: during CAPTURE shorten one line to 799 clocks -> locked=0 next cycle, writes stop, no done, busy stays 1; two good frames later capture restarts at addra=0 and completes.
- start while busy ignored (single done); start while unlocked waits in ARM with wea=0 until lock.
- Async rst mid-capture -> wea/busy 0 immediately, FSM IDLE, locked 0.
